// File: rtl/qdma_ep_pio_completer.sv
// qdma_ep_pio_completer
//   PIO target for a PCIe endpoint. It services memory write and memory read
//   requests aimed at a dword RAM behind a BAR. Writes are posted and produce
//   no completion. Reads return one completion beat per dword. A request whose
//   length exceeds the max payload, or that runs past the end of the RAM, is
//   rejected with Unsupported Request. A rejected write still has its data
//   beats drained.
//
// Ports
//   sys_clk, sys_rst   clock and asynchronous active-high reset
//   req_*              request channel (write/read, tag, dword address, length)
//   wr_*               write data beats (data + byte enables)
//   cpl_*              completion beats (tag, data, status, last)
//   err_ur             one-cycle pulse for each rejected request
//
// Handshakes: a beat moves on a channel in any cycle where its valid and ready
// are both high at the rising clock edge. A producer holds valid and payload
// stable until that happens. cpl_* is registered and holds while cpl_ready=0.
module qdma_ep_pio_completer #(
  parameter logic [2:0] MAX_PAYLOAD_SIZE = 3'b011,
  parameter int         MEM_DWORDS       = 512,
  parameter int         AW               = 9
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [7:0]    req_tag,
  input  logic [AW-1:0] req_dw_addr,
  input  logic [9:0]    req_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [31:0]   wr_data,
  input  logic [3:0]    wr_be,
  output logic          cpl_valid,
  input  logic          cpl_ready,
  output logic [7:0]    cpl_tag,
  output logic [31:0]   cpl_data,
  output logic [2:0]    cpl_status,
  output logic          cpl_last,
  output logic          err_ur
);

  localparam int LIMIT = 32 << int'(MAX_PAYLOAD_SIZE);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_READ   = 3'd3,
    ST_UR_CPL = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic          req_ready_q, req_ready_d;
  logic          wr_ready_q, wr_ready_d;
  logic          cpl_valid_q, cpl_valid_d;
  logic [7:0]    cpl_tag_q, cpl_tag_d;
  logic [31:0]   cpl_data_q, cpl_data_d;
  logic [2:0]    cpl_status_q, cpl_status_d;
  logic          cpl_last_q, cpl_last_d;
  logic          err_ur_q, err_ur_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [10:0]   cnt_q, cnt_d;      // beats still to move, including the current one

  logic [31:0]   mem [MEM_DWORDS];

  logic          req_fire, wr_fire, cpl_fire, req_bad, mem_we;
  logic [10:0]   req_len_eff;
  logic [AW-1:0] addr_nxt;

  assign req_fire    = req_valid & req_ready_q;
  assign wr_fire     = wr_valid & wr_ready_q;
  assign cpl_fire    = cpl_valid_q & cpl_ready;
  assign req_len_eff = (req_len == 10'd0) ? 11'd1024 : {1'b0, req_len};
  assign req_bad     = (int'(req_len_eff) > LIMIT) ||
                       (int'(req_dw_addr) + int'(req_len_eff) > MEM_DWORDS);
  assign addr_nxt    = addr_q + AW'(1);

  always_comb begin
    state_d      = state_q;
    cpl_valid_d  = cpl_valid_q;
    cpl_tag_d    = cpl_tag_q;
    cpl_data_d   = cpl_data_q;
    cpl_status_d = cpl_status_q;
    cpl_last_d   = cpl_last_q;
    err_ur_d     = 1'b0;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    mem_we       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          addr_d    = req_dw_addr;
          cnt_d     = req_len_eff;
          err_ur_d  = req_bad;
          cpl_tag_d = req_tag;
          if (req_write) begin
            state_d = req_bad ? ST_DRAIN : ST_WRITE;
          end else if (req_bad) begin
            state_d      = ST_UR_CPL;
            cpl_valid_d  = 1'b1;
            cpl_data_d   = 32'h0;
            cpl_status_d = 3'b001;
            cpl_last_d   = 1'b1;
          end else begin
            // First beat is fetched here so it is on the outputs next cycle.
            state_d      = ST_READ;
            cpl_valid_d  = 1'b1;
            cpl_data_d   = mem[req_dw_addr];
            cpl_status_d = 3'b000;
            cpl_last_d   = (req_len_eff == 11'd1);
          end
        end
      end
      ST_WRITE, ST_DRAIN: begin
        if (wr_fire) begin
          mem_we = (state_q == ST_WRITE);
          addr_d = addr_nxt;
          cnt_d  = cnt_q - 11'd1;
          if (cnt_q == 11'd1) state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (cpl_fire) begin
          if (cpl_last_q) begin
            state_d     = ST_IDLE;
            cpl_valid_d = 1'b0;
            cpl_last_d  = 1'b0;
          end else begin
            // Prefetch the next dword so the following beat has no bubble.
            addr_d     = addr_nxt;
            cnt_d      = cnt_q - 11'd1;
            cpl_data_d = mem[addr_nxt];
            cpl_last_d = (cnt_q == 11'd2);
          end
        end
      end
      ST_UR_CPL: begin
        if (cpl_fire) begin
          state_d      = ST_IDLE;
          cpl_valid_d  = 1'b0;
          cpl_last_d   = 1'b0;
          cpl_status_d = 3'b000;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Ready flags are registered from the next state so they read 0 in reset.
    req_ready_d = (state_d == ST_IDLE);
    wr_ready_d  = (state_d == ST_WRITE) || (state_d == ST_DRAIN);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b0;
      wr_ready_q   <= 1'b0;
      cpl_valid_q  <= 1'b0;
      cpl_tag_q    <= 8'h0;
      cpl_data_q   <= 32'h0;
      cpl_status_q <= 3'b000;
      cpl_last_q   <= 1'b0;
      err_ur_q     <= 1'b0;
      addr_q       <= '0;
      cnt_q        <= 11'd0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      wr_ready_q   <= wr_ready_d;
      cpl_valid_q  <= cpl_valid_d;
      cpl_tag_q    <= cpl_tag_d;
      cpl_data_q   <= cpl_data_d;
      cpl_status_q <= cpl_status_d;
      cpl_last_q   <= cpl_last_d;
      err_ur_q     <= err_ur_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
    end
  end

  // RAM has no reset; byte lanes are written only where wr_be is set.
  always_ff @(posedge sys_clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[addr_q][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign wr_ready   = wr_ready_q;
  assign cpl_valid  = cpl_valid_q;
  assign cpl_tag    = cpl_tag_q;
  assign cpl_data   = cpl_data_q;
  assign cpl_status = cpl_status_q;
  assign cpl_last   = cpl_last_q;
  assign err_ur     = err_ur_q;

endmodule

// File: tb/tb_qdma_ep_pio_completer.sv
module tb_qdma_ep_pio_completer;

  localparam int LIMIT = 256;
  localparam int MEMD  = 512;

  // ---------------- clock / reset ----------------
  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        req_valid, req_ready, req_write;
  logic [7:0]  req_tag;
  logic [8:0]  req_dw_addr;
  logic [9:0]  req_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        cpl_valid, cpl_ready;
  logic [7:0]  cpl_tag;
  logic [31:0] cpl_data;
  logic [2:0]  cpl_status;
  logic        cpl_last, err_ur;

  always #5 sys_clk = ~sys_clk;

  qdma_ep_pio_completer dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_tag(req_tag), .req_dw_addr(req_dw_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_be(wr_be),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_tag(cpl_tag),
    .cpl_data(cpl_data), .cpl_status(cpl_status), .cpl_last(cpl_last),
    .err_ur(err_ur)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] model_mem [MEMD];
  logic [31:0] wq_data[$];
  logic [3:0]  wq_be[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] nw,
                                           input logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic int eff_len(input logic [9:0] len);
    return (len == 10'd0) ? 1024 : int'(len);
  endfunction

  function automatic bit is_bad(input logic [8:0] addr, input logic [9:0] len);
    return (eff_len(len) > LIMIT) || (int'(addr) + eff_len(len) > MEMD);
  endfunction

  // ---------------- driver tasks ----------------
  // Drives one request; returns one cycle after the accepting edge.
  task automatic send_req(input logic w, input logic [7:0] tag, input logic [8:0] addr,
                          input logic [9:0] len);
    bit done = 0;
    int n = 0;
    req_valid = 1'b1; req_write = w; req_tag = tag; req_dw_addr = addr; req_len = len;
    while (!done) begin
      done = req_ready;
      @(posedge sys_clk); #1;
      n++;
      if (!done && n > 100) begin
        check("req_timeout", 64'd1, 64'd0);
        break;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] tag, input logic [8:0] addr, input logic [9:0] len);
    int L = eff_len(len);
    bit bad = is_bad(addr, len);
    int cyc = 0;
    bit tmo = 0;
    send_req(1'b1, tag, addr, len);
    check("wr_err_ur", 64'(err_ur), 64'(bad));
    for (int i = 0; i < L && !tmo; i++) begin
      logic [31:0] d = (wq_data.size() > 0) ? wq_data.pop_front() : $urandom;
      logic [3:0]  be = (wq_be.size() > 0) ? wq_be.pop_front() : 4'hF;
      bit done = 0;
      while (!done) begin
        wr_valid = ($urandom_range(0, 3) != 0);
        wr_data  = d;
        wr_be    = be;
        done     = wr_valid && wr_ready;
        @(posedge sys_clk); #1;
        cyc++;
        if (!done && cyc > 6000) begin
          check("wr_timeout", 64'd1, 64'd0);
          tmo = 1;
          break;
        end
      end
      if (done && !bad) model_mem[int'(addr) + i] = merge_be(model_mem[int'(addr) + i], d, be);
    end
    wr_valid = 1'b0;
    wq_data.delete();
    wq_be.delete();
    check("wr_done", {61'd0, req_ready, cpl_valid, err_ur}, 64'b100);
  endtask

  // mode: 0 = cpl_ready always high, 1 = toggles every cycle, 2 = random
  task automatic do_read(input logic [7:0] tag, input logic [8:0] addr, input logic [9:0] len,
                         input int mode);
    logic [43:0] exp_q[$];
    int L = eff_len(len);
    bit bad = is_bad(addr, len);
    int cyc = 0;
    if (bad) exp_q.push_back({tag, 3'b001, 1'b1, 32'h0});
    else for (int i = 0; i < L; i++)
      exp_q.push_back({tag, 3'b000, (i == L - 1), model_mem[int'(addr) + i]});
    send_req(1'b0, tag, addr, len);
    check("rd_err_ur", 64'(err_ur), 64'(bad));
    while (exp_q.size() > 0) begin
      bit hs;
      case (mode)
        0:       cpl_ready = 1'b1;
        1:       cpl_ready = cyc[0];
        default: cpl_ready = ($urandom_range(0, 2) != 0);
      endcase
      check("rd_beat", {19'd0, cpl_valid, cpl_tag, cpl_status, cpl_last, cpl_data},
            {19'd0, 1'b1, exp_q[0]});
      hs = cpl_valid && cpl_ready;
      @(posedge sys_clk); #1;
      cyc++;
      if (hs) void'(exp_q.pop_front());
      if (cyc > 4000) begin
        check("rd_timeout", 64'd1, 64'd0);
        break;
      end
    end
    cpl_ready = 1'b0;
    check("rd_done", {61'd0, cpl_valid, req_ready, err_ur}, 64'b010);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    sys_rst = 1'b1;
    req_valid = 0; req_write = 0; req_tag = 0; req_dw_addr = 0; req_len = 0;
    wr_valid = 0; wr_data = 0; wr_be = 0; cpl_ready = 0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("reset_outputs",
          {17'd0, req_ready, wr_ready, cpl_valid, cpl_last, cpl_tag, cpl_data, cpl_status, err_ur},
          64'd0);
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;
    check("ready_after_reset", 64'(req_ready), 64'd1);

    // Fill the whole RAM so the model is fully known (256 = exact payload limit).
    do_write(8'h01, 9'h000, 10'd256);
    do_write(8'h02, 9'h100, 10'd256);

    // Single write then read-back.
    wq_data.push_back(32'hDEADBEEF); wq_be.push_back(4'hF);
    do_write(8'h03, 9'h010, 10'd1);
    do_read(8'h05, 9'h010, 10'd1, 0);
    check("deadbeef_model", 64'(model_mem[16]), 64'hDEADBEEF);

    // Four dwords, read back with cpl_ready toggling.
    for (int i = 1; i <= 4; i++) begin wq_data.push_back(i); wq_be.push_back(4'hF); end
    do_write(8'h06, 9'h020, 10'd4);
    do_read(8'h07, 9'h020, 10'd4, 1);

    // Partial byte enables.
    wq_data.push_back(32'hAAAAAAAA); wq_be.push_back(4'hF);
    do_write(8'h08, 9'h030, 10'd1);
    wq_data.push_back(32'h11223344); wq_be.push_back(4'b0101);
    do_write(8'h09, 9'h030, 10'd1);
    check("be_merge_model", 64'(model_mem[48]), 64'hAA22AA44);
    do_read(8'h0A, 9'h030, 10'd1, 0);

    // wr_be = 0000 consumes a beat but writes nothing.
    wq_data.push_back(32'h55555555); wq_be.push_back(4'h0);
    do_write(8'h0B, 9'h030, 10'd1);
    do_read(8'h0C, 9'h030, 10'd1, 2);

    // Oversize requests and the end-of-RAM boundary.
    do_read(8'h0D, 9'h000, 10'd257, 0);
    do_write(8'h0E, 9'h000, 10'd257);
    do_read(8'h0F, 9'h000, 10'd16, 2);
    do_read(8'h10, 9'h1FF, 10'd2, 0);
    do_read(8'h11, 9'h1FF, 10'd1, 0);
    do_read(8'h12, 9'h100, 10'd0, 0);      // len 0 means 1024
    do_read(8'h13, 9'h100, 10'd256, 0);    // ends exactly at the last dword

    // Reset during the 3rd beat of an 8-beat read.
    send_req(1'b0, 8'h20, 9'h040, 10'd8);
    cpl_ready = 1'b1;
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    check("pre_reset_beat3", {31'd0, cpl_valid, cpl_data}, {31'd0, 1'b1, model_mem[66]});
    sys_rst = 1'b1;
    #1;
    check("reset_mid_cpl_valid", 64'(cpl_valid), 64'd0);
    check("reset_mid_req_ready", 64'(req_ready), 64'd0);
    cpl_ready = 1'b0;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;
    check("ready_after_mid_reset", 64'(req_ready), 64'd1);
    do_read(8'h21, 9'h040, 10'd8, 2);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      logic [8:0] a;
      logic [9:0] len;
      logic [7:0] tg = 8'($urandom);
      int sel = $urandom_range(0, 7);
      if (sel == 0) begin
        a = 9'($urandom_range(0, 300));
        len = 10'($urandom_range(254, 258));
      end else if (sel == 1) begin
        a = 9'($urandom_range(500, 511));
        len = 10'($urandom_range(1, 14));
      end else begin
        a = 9'($urandom_range(0, 511));
        len = 10'($urandom_range(1, 12));
      end
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < eff_len(len); i++) begin
          wq_data.push_back($urandom);
          wq_be.push_back(4'($urandom_range(0, 15)));
        end
        do_write(tg, a, len);
      end else begin
        do_read(tg, a, len, $urandom_range(0, 2));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d",
             n_errors, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
